// File: rtl/crossbar_allocator.sv
// Sequential crossbar allocator: per-output round-robin arbitration with packet-long locks.
// Define XBAR_TIMEOUT_EN to build the per-output idle-lock watchdog.
module crossbar_allocator #(
    parameter int unsigned number_ports   = 4,
    parameter int unsigned DEST_W         = $clog2(number_ports),
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [number_ports-1:0]              req_valid,
    input  logic [DEST_W*number_ports-1:0]       req_dest,
    input  logic [number_ports-1:0]              req_last,
    output logic [number_ports-1:0]              req_ready,
    output logic [number_ports*number_ports-1:0] gnt,
    output logic [number_ports*number_ports-1:0] ctr,
    output logic [number_ports-1:0]              out_busy,
    output logic                                 timeout_err
);
    localparam int unsigned N = number_ports;

    if (number_ports < 2 || number_ports > 16 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("crossbar_allocator: illegal parameter set");
    end

    typedef enum logic {IN_IDLE = 1'b0, IN_LOCKED = 1'b1} in_state_e;
    typedef enum logic {OUT_FREE = 1'b0, OUT_BUSY = 1'b1} out_state_e;

    in_state_e         in_state_q  [N];
    in_state_e         in_state_d  [N];
    out_state_e        out_state_q [N];
    out_state_e        out_state_d [N];
    logic [DEST_W-1:0] dest_q      [N];
    logic [DEST_W-1:0] dest_d      [N];
    logic [DEST_W-1:0] ptr_q       [N];
    logic [DEST_W-1:0] ptr_d       [N];
    logic [N*N-1:0]    gnt_q, gnt_d;
    logic [N*N-1:0]    ctr_q, ctr_d;
    logic [N-1:0]      release_c;
    logic [N-1:0]      expire_c;
    logic [N-1:0]      cand_c;
    logic [N-1:0]      sel_c;
    logic              found_c;

`ifdef XBAR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic             err_q, err_d;
    logic [N-1:0]     out_beat_c;

    // Count BUSY cycles with no beat; expiry forces a release like a tail beat.
    always_comb begin
        err_d      = err_q;
        out_beat_c = '0;
        expire_c   = '0;
        for (int o = 0; o < N; o++) begin
            cnt_d[o] = '0;
            for (int i = 0; i < N; i++) begin
                if (gnt_q[o*N+i] && req_valid[i]) begin
                    out_beat_c[o] = 1'b1;
                end
            end
            if (out_state_q[o] == OUT_BUSY && !out_beat_c[o]) begin
                if (cnt_q[o] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    expire_c[o] = 1'b1;
                    err_d       = 1'b1;
                end else begin
                    cnt_d[o] = cnt_q[o] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
            for (int o = 0; o < N; o++) begin
                cnt_q[o] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int o = 0; o < N; o++) begin
                cnt_q[o] <= cnt_d[o];
            end
        end
    end

    assign timeout_err = err_q;
`else
    assign expire_c    = '0;
    assign timeout_err = 1'b0;
`endif

    // Release, arbitration of outputs that were FREE this cycle, and control-word build.
    always_comb begin
        gnt_d     = gnt_q;
        release_c = '0;
        cand_c    = '0;
        sel_c     = '0;
        found_c   = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_state_d[i] = in_state_q[i];
            dest_d[i]     = dest_q[i];
        end
        for (int o = 0; o < N; o++) begin
            out_state_d[o] = out_state_q[o];
            ptr_d[o]       = ptr_q[o];
        end

        for (int i = 0; i < N; i++) begin
            if (in_state_q[i] == IN_LOCKED) begin
                if (req_valid[i] && req_last[i]) begin
                    release_c[i] = 1'b1;
                end
                for (int o = 0; o < N; o++) begin
                    if (gnt_q[o*N+i] && expire_c[o]) begin
                        release_c[i] = 1'b1;
                    end
                end
            end
        end

        for (int i = 0; i < N; i++) begin
            if (release_c[i]) begin
                in_state_d[i] = IN_IDLE;
                for (int o = 0; o < N; o++) begin
                    if (gnt_q[o*N+i]) begin
                        out_state_d[o] = OUT_FREE;
                    end
                    gnt_d[o*N+i] = 1'b0;
                end
            end
        end

        for (int o = 0; o < N; o++) begin
            if (out_state_q[o] == OUT_FREE) begin
                for (int c = 0; c < N; c++) begin
                    cand_c[c] = (in_state_q[c] == IN_IDLE) && req_valid[c] &&
                                (req_dest[c*DEST_W +: DEST_W] == DEST_W'(o));
                end
                found_c = 1'b0;
                sel_c   = '0;
                // Two passes give a wrapping search starting at ptr.
                for (int c = 0; c < N; c++) begin
                    if (!found_c && cand_c[c] && (DEST_W'(c) >= ptr_q[o])) begin
                        found_c  = 1'b1;
                        sel_c[c] = 1'b1;
                    end
                end
                for (int c = 0; c < N; c++) begin
                    if (!found_c && cand_c[c]) begin
                        found_c  = 1'b1;
                        sel_c[c] = 1'b1;
                    end
                end
                for (int c = 0; c < N; c++) begin
                    if (sel_c[c]) begin
                        in_state_d[c]  = IN_LOCKED;
                        dest_d[c]      = DEST_W'(o);
                        out_state_d[o] = OUT_BUSY;
                        gnt_d[o*N+c]   = 1'b1;
                        ptr_d[o]       = DEST_W'((c + 1) % N);
                    end
                end
            end
        end

        ctr_d = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ctr_d[i*N+j] = (in_state_d[i] == IN_LOCKED) && (DEST_W'(j) >= dest_d[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= '0;
            ctr_q <= '0;
            for (int i = 0; i < N; i++) begin
                in_state_q[i]  <= IN_IDLE;
                dest_q[i]      <= '0;
                out_state_q[i] <= OUT_FREE;
                ptr_q[i]       <= '0;
            end
        end else begin
            gnt_q <= gnt_d;
            ctr_q <= ctr_d;
            for (int i = 0; i < N; i++) begin
                in_state_q[i]  <= in_state_d[i];
                dest_q[i]      <= dest_d[i];
                out_state_q[i] <= out_state_d[i];
                ptr_q[i]       <= ptr_d[i];
            end
        end
    end

    assign gnt = gnt_q;
    assign ctr = ctr_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_ready[i] = (in_state_q[i] == IN_LOCKED);
            out_busy[i]  = (out_state_q[i] == OUT_BUSY);
        end
    end

endmodule

// File: tb/tb_crossbar_allocator.sv
// Bench for crossbar_allocator (N=4): directed packet scenarios plus random traffic
// checked against a transaction-level allocation model.
module tb_crossbar_allocator;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*DW-1:0]  req_dest;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [N*N-1:0]   gnt;
    logic [N*N-1:0]   ctr;
    logic [N-1:0]     out_busy;
    logic             timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who owns each output, what each input is locked to, round-robin start points.
    bit m_locked [N];
    int m_dest   [N];
    int m_owner  [N];
    int m_ptr    [N];

    crossbar_allocator #(.number_ports(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .gnt         (gnt),
        .ctr         (ctr),
        .out_busy    (out_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*DW-1:0] pack_dest(input int d0, input int d1, input int d2, input int d3);
        logic [N*DW-1:0] r;
        r[0*DW +: DW] = DW'(d0);
        r[1*DW +: DW] = DW'(d1);
        r[2*DW +: DW] = DW'(d2);
        r[3*DW +: DW] = DW'(d3);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_locked[i] = 1'b0;
            m_dest[i]   = 0;
            m_owner[i]  = -1;
            m_ptr[i]    = 0;
        end
    endtask

    task automatic model_check();
        logic [N*N-1:0] eg, ec;
        logic [N-1:0]   er, eb;
        eg = '0; ec = '0; er = '0; eb = '0;
        for (int i = 0; i < N; i++) begin
            er[i] = m_locked[i];
            for (int j = 0; j < N; j++) begin
                ec[i*N+j] = m_locked[i] && (j >= m_dest[i]);
            end
        end
        for (int o = 0; o < N; o++) begin
            eb[o] = (m_owner[o] >= 0);
            for (int i = 0; i < N; i++) begin
                eg[o*N+i] = (m_owner[o] == i);
            end
        end
        check_eq("req_ready", 64'(req_ready), 64'(er));
        check_eq("gnt", 64'(gnt), 64'(eg));
        check_eq("ctr", 64'(ctr), 64'(ec));
        check_eq("out_busy", 64'(out_busy), 64'(eb));
        check_eq("timeout_err", 64'(timeout_err), 64'(0));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit n_locked [N];
        int n_dest   [N];
        int n_owner  [N];
        for (int i = 0; i < N; i++) begin
            n_locked[i] = m_locked[i];
            n_dest[i]   = m_dest[i];
            n_owner[i]  = m_owner[i];
        end
        for (int i = 0; i < N; i++) begin
            if (m_locked[i] && req_valid[i] && req_last[i]) begin
                n_locked[i]        = 1'b0;
                n_owner[m_dest[i]] = -1;
            end
        end
        for (int o = 0; o < N; o++) begin
            if (m_owner[o] < 0) begin
                bit done;
                done = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr[o] + k) % N;
                    if (!done && !m_locked[c] && req_valid[c] && (int'(req_dest[c*DW +: DW]) == o)) begin
                        done        = 1'b1;
                        n_locked[c] = 1'b1;
                        n_dest[c]   = o;
                        n_owner[o]  = c;
                        m_ptr[o]    = (c + 1) % N;
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            m_locked[i] = n_locked[i];
            m_dest[i]   = n_dest[i];
            m_owner[i]  = n_owner[i];
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N-1:0] l);
        @(posedge clk);
        #1;
        req_valid = v;
        req_dest  = d;
        req_last  = l;
        @(negedge clk);
        model_check();
        model_step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [$];
        logic [N-1:0] col, prev_col;

        rst       = 1'b1;
        req_valid = '0;
        req_dest  = '0;
        req_last  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_gnt", 64'(gnt), 64'(0));
        check_eq("rst_ctr", 64'(ctr), 64'(0));
        check_eq("rst_ready", 64'(req_ready), 64'(0));
        check_eq("rst_busy", 64'(out_busy), 64'(0));
        rst = 1'b0;

        // 3-beat packet 2->3; dest flips to 0 mid-packet and must be ignored
        step(4'b0100, pack_dest(0, 0, 3, 0), 4'b0000);
        step(4'b0100, pack_dest(0, 0, 3, 0), 4'b0000);
        check_eq("s1_gnt_3_2", 64'(gnt[3*N+2]), 64'(1));
        check_eq("s1_ctr_row2", 64'(ctr[2*N +: N]), 64'(4'b1000));
        check_eq("s1_busy3", 64'(out_busy[3]), 64'(1));
        step(4'b0100, pack_dest(0, 0, 0, 0), 4'b0000);
        step(4'b0100, pack_dest(0, 0, 0, 0), 4'b0100);
        check_eq("s4_ctr_row2", 64'(ctr[2*N +: N]), 64'(4'b1000));
        check_eq("s4_busy0", 64'(out_busy[0]), 64'(0));
        check_eq("s1_ready2_last", 64'(req_ready[2]), 64'(1));
        step(4'b0000, pack_dest(0, 0, 0, 0), 4'b0000);
        check_eq("s1_ready2_drop", 64'(req_ready[2]), 64'(0));
        check_eq("s1_busy3_drop", 64'(out_busy[3]), 64'(0));

        // Round robin on output 1 among inputs 0, 1, 3 with single-beat packets
        prev_col = '0;
        for (int s = 0; s < 10; s++) begin
            step(4'b1011, pack_dest(1, 1, 1, 1), 4'b1111);
            col = gnt[1*N +: N];
            if (col != '0 && prev_col == '0) begin
                for (int i = 0; i < N; i++) begin
                    if (col[i]) order.push_back(i);
                end
            end
            prev_col = col;
        end
        step(4'b0000, pack_dest(0, 0, 0, 0), 4'b0000);
        check_eq("rr_count_ge4", 64'(order.size() >= 4), 64'(1));
        if (order.size() >= 4) begin
            check_eq("rr_g0", 64'(order[0]), 64'(0));
            check_eq("rr_g1", 64'(order[1]), 64'(1));
            check_eq("rr_g2", 64'(order[2]), 64'(3));
            check_eq("rr_g3", 64'(order[3]), 64'(0));
        end

        // Simultaneous grants to different outputs
        step(4'b0011, pack_dest(0, 2, 0, 0), 4'b0011);
        step(4'b0011, pack_dest(0, 2, 0, 0), 4'b0011);
        check_eq("s3_ctr_row0", 64'(ctr[0*N +: N]), 64'(4'b1111));
        check_eq("s3_ctr_row1", 64'(ctr[1*N +: N]), 64'(4'b1100));
        check_eq("s3_gnt_0_0", 64'(gnt[0*N+0]), 64'(1));
        check_eq("s3_gnt_2_1", 64'(gnt[2*N+1]), 64'(1));
        step(4'b0000, pack_dest(0, 0, 0, 0), 4'b0000);

        // Async reset mid-packet, then arbitration restarts from ptr 0
        step(4'b1000, pack_dest(0, 0, 0, 1), 4'b0000);
        step(4'b1000, pack_dest(0, 0, 0, 1), 4'b0000);
        check_eq("rst_mid_locked", 64'(req_ready[3]), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_gnt", 64'(gnt), 64'(0));
        check_eq("arst_ctr", 64'(ctr), 64'(0));
        check_eq("arst_ready", 64'(req_ready), 64'(0));
        check_eq("arst_busy", 64'(out_busy), 64'(0));
        req_valid = '0;
        req_dest  = '0;
        req_last  = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(4'b1010, pack_dest(0, 2, 0, 2), 4'b0000);
        step(4'b1010, pack_dest(0, 2, 0, 2), 4'b0000);
        check_eq("arst_ptr0_gnt_2_1", 64'(gnt[2*N+1]), 64'(1));
        step(4'b1010, pack_dest(0, 2, 0, 2), 4'b0010);
        step(4'b1000, pack_dest(0, 2, 0, 2), 4'b0000);
        step(4'b1000, pack_dest(0, 2, 0, 2), 4'b1000);
        step(4'b0000, pack_dest(0, 0, 0, 0), 4'b0000);

        // Random traffic against the model
        for (int s = 0; s < 500; s++) begin
            step(N'($urandom | $urandom), (N*DW)'($urandom), N'($urandom & $urandom));
        end
        for (int s = 0; s < 3; s++) begin
            step(4'b1111, (N*DW)'($urandom), 4'b1111);
        end
        step(4'b0000, pack_dest(0, 0, 0, 0), 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
